breath_pwm_multi: RTL

Multi-channel breathing-LED PWM generator, successor to the single-channel fixed-ramp breathing driver. Entirely in the clk_in domain: a prescaler produces a one-cycle clock-enable tick, and no derived clocks are used. One shared PWM counter and step scheduler feed CHANNELS independent brightness engines. Each engine is selectable as off, sawtooth, triangle or static. Sits directly in front of the board LED pins.

---
 rtl/breath_pwm_pkg.sv | 18 +
 rtl/breath_pwm_chan.sv | 84 ++++++++
 rtl/breath_pwm_multi.sv | 90 +++++++++
 3 files changed

// File: rtl/breath_pwm_pkg.sv
// Purpose: shared mode encoding and helpers for the multi-channel breathing PWM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package breath_pwm_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF    = 2'b00;
    localparam mode_t MODE_SAW    = 2'b01;
    localparam mode_t MODE_TRI    = 2'b10;
    localparam mode_t MODE_STATIC = 2'b11;

    // Full-scale brightness for a given level width (all ones).
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/breath_pwm_chan.sv
// Purpose: one channel's brightness engine (off/sawtooth/triangle/static) and PWM compare.
// Latency: level moves on the edge after step; pwm_out is registered, one cycle behind pwm_cnt.
// Backpressure: none; free-running, level only changes on a step so duty is glitch-free.
module breath_pwm_chan
    import breath_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                step,
    input  mode_t               mode,
    input  logic [PWM_BITS-1:0] static_level,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] level
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic                dir_up_q, dir_up_d;
    mode_t               prev_mode_q, prev_mode_d;
    logic                pwm_out_q, pwm_out_d;
    logic                move_up;

    // Next level/direction, evaluated only on a step; compare runs every cycle.
    always_comb begin
        level_d     = level_q;
        dir_up_d    = dir_up_q;
        prev_mode_d = prev_mode_q;
        move_up     = dir_up_q;
        pwm_out_d   = (pwm_cnt < level_q);
        if (step) begin
            prev_mode_d = mode;
            case (mode)
                MODE_OFF: begin
                    level_d  = '0;
                    dir_up_d = 1'b1;
                end
                MODE_SAW: begin
                    // MAX is all ones, so the natural carry-out gives MAX -> 0.
                    level_d = level_q + LVL_ONE;
                end
                MODE_TRI: begin
                    // Fresh entry starts upward; the rails override so peaks/troughs last one step.
                    if (prev_mode_q != MODE_TRI) begin
                        move_up = 1'b1;
                    end
                    if (level_q == LVL_MAX) begin
                        move_up = 1'b0;
                    end else if (level_q == '0) begin
                        move_up = 1'b1;
                    end
                    level_d  = move_up ? (level_q + LVL_ONE) : (level_q - LVL_ONE);
                    dir_up_d = move_up;
                end
                default: begin
                    level_d = static_level;
                end
            endcase
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            level_q     <= '0;
            dir_up_q    <= 1'b1;
            prev_mode_q <= MODE_OFF;
            pwm_out_q   <= 1'b0;
        end else begin
            level_q     <= level_d;
            dir_up_q    <= dir_up_d;
            prev_mode_q <= prev_mode_d;
            pwm_out_q   <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;
    assign level   = level_q;

endmodule

// File: rtl/breath_pwm_multi.sv
// Purpose: shared prescaler, PWM counter and step scheduler driving CHANNELS breathing engines.
// Latency: strobes one cycle after the wrap/step event; pwm_out one cycle behind pwm_cnt.
// Backpressure: none; free-running LED driver.
module breath_pwm_multi
    import breath_pwm_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 8,
    parameter int PRESC_DIV    = 94,
    parameter int STEP_PERIODS = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PWM_BITS*CHANNELS-1:0] static_level,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_strobe,
    output logic                         step_strobe,
    output logic [PWM_BITS*CHANNELS-1:0] level
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST   = PWM_BITS'(pwm_max(PWM_BITS) - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic                period_strobe_q, period_strobe_d;
    logic                step_strobe_q, step_strobe_d;
    logic                tick, wrap, step;

    // Prescaler tick, PWM counter wrap and step scheduling shared by all channels.
    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        wrap       = tick && (pwm_cnt_q == CNT_LAST);
        step       = wrap && (step_cnt_q == STEP_LAST);
        presc_d    = tick ? '0 : (presc_q + PW'(1));
        pwm_cnt_d  = pwm_cnt_q;
        step_cnt_d = step_cnt_q;
        if (tick) begin
            pwm_cnt_d = wrap ? '0 : (pwm_cnt_q + PWM_BITS'(1));
        end
        if (wrap) begin
            step_cnt_d = step ? '0 : (step_cnt_q + SW'(1));
        end
        period_strobe_d = wrap;
        step_strobe_d   = step;
    end

    // Timebase registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            presc_q         <= '0;
            pwm_cnt_q       <= '0;
            step_cnt_q      <= '0;
            period_strobe_q <= 1'b0;
            step_strobe_q   <= 1'b0;
        end else begin
            presc_q         <= presc_d;
            pwm_cnt_q       <= pwm_cnt_d;
            step_cnt_q      <= step_cnt_d;
            period_strobe_q <= period_strobe_d;
            step_strobe_q   <= step_strobe_d;
        end
    end

    assign period_strobe = period_strobe_q;
    assign step_strobe   = step_strobe_q;

    // Steps only fire on a wrap, so new levels take effect exactly at pwm_cnt = 0.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        breath_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk_in       (clk_in),
            .rst_n        (rst_n),
            .step         (step),
            .mode         (mode[2*i +: 2]),
            .static_level (static_level[i*PWM_BITS +: PWM_BITS]),
            .pwm_cnt      (pwm_cnt_q),
            .pwm_out      (pwm_out[i]),
            .level        (level[i*PWM_BITS +: PWM_BITS])
        );
    end

endmodule
